shift_sequencer: RTL and testbench

Multi-cycle shift controller for the ALU shifting datapath. It sequences one shared single-stage shift unit through the 16/8/4/2/1 power-of-two steps, applying one step per cycle. This replaces the area-heavy five-stage combinational barrel chain in a low-area ALU configuration. It accepts one shift request at a time over a start/busy handshake and returns the result with a one-cycle valid pulse, at fixed latency.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_stage.sv | 27 ++
 rtl/shift_sequencer.sv | 97 +++++++++
 tb/tb_shift_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared op codes, FSM encoding and default geometry for the multi-cycle shifter.
package shift_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 5;

  localparam logic SHIFT_SLL = 1'b0;
  localparam logic SHIFT_SRA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift step, combinational; step 0 is the largest distance.
// The distance is 2^(STAGES-1-step); sra replicates the current sign bit.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic [WIDTH-1:0]          in,
  input  logic                      op,
  input  logic [$clog2(STAGES)-1:0] step,
  output logic [WIDTH-1:0]          out
);
  localparam int STEP_W = $clog2(STAGES);

  logic [STEP_W-1:0]        w_sel;
  logic [STAGES-1:0]        w_dist;
  logic [WIDTH-1:0]         w_sll;
  logic signed [WIDTH-1:0]  w_sra;

  assign w_sel  = STEP_W'(STAGES - 1) - step;
  assign w_dist = STAGES'(1) << w_sel;
  assign w_sll  = in << w_dist;
  // Kept in its own signed net so the arithmetic shift is not widened to unsigned.
  assign w_sra  = $signed(in) >>> w_dist;
  assign out    = (op == SHIFT_SRA) ? w_sra : w_sll;
endmodule

// File: rtl/shift_sequencer.sv
// Sequences one shared shift stage through STAGES steps: result 5 edges after accept, valid pulse in DONE.
// start is only taken in IDLE/DONE (busy otherwise); flush aborts to IDLE with no result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [STAGES-1:0] shamt,
  input  logic              flush,
  output logic              busy,
  output logic              result_valid,
  output logic [WIDTH-1:0]  data_out
);
  localparam int STEP_W = $clog2(STAGES);

  state_t              r_state;
  logic [WIDTH-1:0]    r_acc;
  logic [STAGES-1:0]   r_shamt;
  logic                r_op;
  logic [STEP_W-1:0]   r_step;

  logic [STEP_W-1:0]   w_bit;
  logic                w_apply;
  logic [WIDTH-1:0]    w_stage_out;
  logic [WIDTH-1:0]    w_acc_next;

  assign w_bit      = STEP_W'(STAGES - 1) - r_step;
  assign w_apply    = r_shamt[w_bit];
  assign w_acc_next = w_apply ? w_stage_out : r_acc;

  shift_stage #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_stage (
    .in   (r_acc),
    .op   (r_op),
    .step (r_step),
    .out  (w_stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_shamt      <= '0;
      r_op         <= SHIFT_SLL;
      r_step       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      data_out     <= '0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_step  <= '0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          // DONE hands back to IDLE but also takes a waiting start, so requests issue every 6 cycles.
          IDLE, DONE: begin
            if (start) begin
              r_acc   <= data_in;
              r_shamt <= shamt;
              r_op    <= op;
              r_step  <= '0;
              r_state <= SHIFT;
              busy    <= 1'b1;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
          SHIFT: begin
            r_acc  <= w_acc_next;
            r_step <= r_step + STEP_W'(1);
            if (r_step == STEP_W'(STAGES - 1)) begin
              r_state      <= DONE;
              r_step       <= '0;
              data_out     <= w_acc_next;
              result_valid <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: edge-counting reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_shift_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        busy;
  logic        result_valid;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_err = 0;
  int edge_cnt = 0;

  // reference model state
  bit          m_pend = 0;
  int          m_acc = 0;
  logic [31:0] m_res = '0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_dout = '0;

  int          res_t[$];
  logic [31:0] res_d[$];

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(32), .STAGES(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .data_in      (data_in),
    .shamt        (shamt),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .data_out     (data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic o, input logic [31:0] d, input logic [4:0] s);
    logic signed [31:0] sd;
    sd = d;
    if (o) return sd >>> s;
    return d << s;
  endfunction

  // Accept at edge A (idle, or A = previous accept + 6); result at A+5; idle again at A+6.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 0; m_busy = 1'b0; m_valid = 1'b0; m_dout = '0;
    end else begin
      edge_cnt++;
      if (flush) begin
        m_pend = 0; m_busy = 1'b0; m_valid = 1'b0;
      end else if (m_pend && edge_cnt == m_acc + 5) begin
        m_valid = 1'b1;
        m_dout  = m_res;
      end else if (!m_pend || edge_cnt == m_acc + 6) begin
        m_valid = 1'b0;
        m_pend  = 0;
        if (start) begin
          m_pend = 1;
          m_acc  = edge_cnt;
          m_res  = ref_shift(op, data_in, shamt);
        end
        m_busy = m_pend;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("cyc busy", {31'b0, busy}, {31'b0, m_busy});
      check("cyc result_valid", {31'b0, result_valid}, {31'b0, m_valid});
      check("cyc data_out", data_out, m_dout);
      if (result_valid) begin
        res_t.push_back(edge_cnt);
        res_d.push_back(data_out);
      end
    end
  end

  task automatic do_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] exp, input string name);
    int cnt;
    bit seen;
    @(negedge clock);
    start = 1'b1; op = o; data_in = d; shamt = s;
    cnt = 0; seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clock);
      start = 1'b0;
      cnt++;
      if (result_valid) seen = 1;
    end
    check({name, " result"}, data_out, exp);
    check({name, " latency"}, cnt, 6);
    @(negedge clock);
    check({name, " busy after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] b2b_exp [3];
    b2b_exp[0] = 32'h10; b2b_exp[1] = 32'h70; b2b_exp[2] = 32'hD0;

    #22 reset_n = 1'b1;
    @(negedge clock);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset result_valid", {31'b0, result_valid}, 32'd0);
    check("reset data_out", data_out, 32'd0);

    do_op(1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra_neg_by4");
    do_op(1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_one_by31");
    do_op(1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678, "sll_by0");
    do_op(1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, "sra_pos_by31");
    do_op(1'b1, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFF, "sra_ones_by17");
    do_op(1'b0, 32'hABCD_1234, 5'd12, 32'hD123_4000, "sll_by12");
    do_op(1'b1, 32'h8000_0001, 5'd1,  32'hC000_0000, "sra_by1");

    // start held high with a new operand every cycle
    res_t.delete(); res_d.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      start = 1'b1; op = 1'b0; data_in = 32'(i + 1); shamt = 5'd4;
    end
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("b2b count", res_d.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < res_d.size()) check("b2b value", res_d[i], b2b_exp[i]);
    end
    if (res_t.size() >= 3) begin
      check("b2b gap1", res_t[1] - res_t[0], 32'd6);
      check("b2b gap2", res_t[2] - res_t[1], 32'd6);
    end

    // flush while step_q is 2
    res_t.delete(); res_d.delete();
    @(negedge clock);
    start = 1'b1; op = 1'b0; data_in = 32'h0000_000F; shamt = 5'd8;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    repeat (8) @(negedge clock);
    check("flush no result", res_d.size(), 32'd0);
    check("flush data_out kept", data_out, 32'h0000_00D0);
    check("flush busy", {31'b0, busy}, 32'd0);
    do_op(1'b0, 32'h0000_000F, 5'd8, 32'h0000_0F00, "after_flush");

    // flush beats start in the same cycle
    @(negedge clock);
    start = 1'b1; flush = 1'b1; op = 1'b0; data_in = 32'h1; shamt = 5'd1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("flush prio busy", {31'b0, busy}, 32'd0);
    repeat (7) @(negedge clock);
    check("flush prio data_out", data_out, 32'h0000_0F00);

    // asynchronous reset at step 3
    res_t.delete(); res_d.delete();
    @(negedge clock);
    start = 1'b1; op = 1'b1; data_in = 32'h8000_0000; shamt = 5'd3;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", {31'b0, busy}, 32'd0);
    check("async rst result_valid", {31'b0, result_valid}, 32'd0);
    check("async rst data_out", data_out, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("rst no result", res_d.size(), 32'd0);
    check("rst busy idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
